// File: rtl/jtag_tap_responder_if.sv
// Host-side JTAG pins and debug readback of the target TAP.
// The host (master) drives the raw JTAG inputs; the TAP (slave) answers.
interface jtag_tap_responder_if;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic       trst_n;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] ir_value;
    logic [7:0] user_reg;

    modport master (
        output tck, tms, tdi, trst_n,
        input  tdo, tdo_oe, tap_state, ir_value, user_reg
    );

    modport slave (
        input  tck, tms, tdi, trst_n,
        output tdo, tdo_oe, tap_state, ir_value, user_reg
    );
endinterface

// File: rtl/jtag_tap_responder.sv
// Oversampled IEEE 1149.1 TAP: 4-bit IR, IDCODE, BYPASS and 8-bit USER DR.
// All JTAG pins are synchronized into clk; TCK edges become single-cycle strobes.
module jtag_tap_responder #(
    parameter logic [31:0] IDCODE      = 32'h1BB1_0001,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    jtag_tap_responder_if.slave jtag
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4,
        CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PAU_IR = 4'hB,
        EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [3:0] IR_IDCODE = 4'b0001;
    localparam logic [3:0] IR_USER   = 4'b0010;

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q;
    logic [SYNC_STAGES-1:0] tdi_sync_q, trst_sync_q;
    logic                   tck_prev_q;
    logic                   tck_s, tms_s, tdi_s, trst_s;
    logic                   rise, fall;

    tap_state_e  state_q, state_d;
    logic [3:0]  ir_shift_q, ir_value_q;
    logic [31:0] dr_shift_q, dr_capture, dr_shifted;
    logic [7:0]  user_q;
    logic        tdo_q, tdo_oe_q;

    function automatic tap_state_e tap_next(tap_state_e s, logic m);
        tap_state_e n;
        n = TLR;
        case (s)
            TLR:    n = m ? TLR    : RTI;
            RTI:    n = m ? SEL_DR : RTI;
            SEL_DR: n = m ? SEL_IR : CAP_DR;
            CAP_DR: n = m ? EX1_DR : SH_DR;
            SH_DR:  n = m ? EX1_DR : SH_DR;
            EX1_DR: n = m ? UPD_DR : PAU_DR;
            PAU_DR: n = m ? EX2_DR : PAU_DR;
            EX2_DR: n = m ? UPD_DR : SH_DR;
            UPD_DR: n = m ? SEL_DR : RTI;
            SEL_IR: n = m ? TLR    : CAP_IR;
            CAP_IR: n = m ? EX1_IR : SH_IR;
            SH_IR:  n = m ? EX1_IR : SH_IR;
            EX1_IR: n = m ? UPD_IR : PAU_IR;
            PAU_IR: n = m ? EX2_IR : PAU_IR;
            EX2_IR: n = m ? UPD_IR : SH_IR;
            UPD_IR: n = m ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    assign tck_s  = tck_sync_q[SYNC_STAGES-1];
    assign tms_s  = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s  = tdi_sync_q[SYNC_STAGES-1];
    assign trst_s = trst_sync_q[SYNC_STAGES-1];
    assign rise   = tck_s & ~tck_prev_q;
    assign fall   = ~tck_s & tck_prev_q;

    assign state_d = tap_next(state_q, tms_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0], jtag.tck};
            tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0], jtag.tms};
            tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0], jtag.tdi};
            trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag.trst_n};
            tck_prev_q  <= tck_s;
        end
    end

    // Selected DR: capture value and one LSB-first shift step at its length.
    always_comb begin
        dr_capture = '0;
        dr_shifted = '0;
        case (ir_value_q)
            IR_IDCODE: begin
                dr_capture = IDCODE;
                dr_shifted = {tdi_s, dr_shift_q[31:1]};
            end
            IR_USER: begin
                dr_capture = {24'h0, user_q};
                dr_shifted = {24'h0, tdi_s, dr_shift_q[7:1]};
            end
            default: dr_shifted = {31'h0, tdi_s};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TLR;
            ir_shift_q <= '0;
            ir_value_q <= IR_IDCODE;
            dr_shift_q <= '0;
            user_q     <= '0;
            tdo_q      <= 1'b0;
            tdo_oe_q   <= 1'b0;
        end else begin
            if (!trst_s) begin
                state_q    <= TLR;
                ir_value_q <= IR_IDCODE;
            end else if (rise) begin
                state_q <= state_d;
                case (state_q)
                    CAP_IR: ir_shift_q <= 4'b0101;
                    SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[3:1]};
                    UPD_IR: ir_value_q <= ir_shift_q;
                    CAP_DR: dr_shift_q <= dr_capture;
                    SH_DR:  dr_shift_q <= dr_shifted;
                    UPD_DR: begin
                        if (ir_value_q == IR_USER)
                            user_q <= dr_shift_q[7:0];
                    end
                    default: ;
                endcase
                if (state_q == TLR || state_d == TLR)
                    ir_value_q <= IR_IDCODE;
            end
            // TDO changes on the falling edge so the host samples it stable.
            if (fall) begin
                case (state_q)
                    SH_IR: begin
                        tdo_q    <= ir_shift_q[0];
                        tdo_oe_q <= 1'b1;
                    end
                    SH_DR: begin
                        tdo_q    <= dr_shift_q[0];
                        tdo_oe_q <= 1'b1;
                    end
                    default: begin
                        tdo_q    <= 1'b0;
                        tdo_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign jtag.tdo       = tdo_q;
    assign jtag.tdo_oe    = tdo_oe_q;
    assign jtag.tap_state = state_q;
    assign jtag.ir_value  = ir_value_q;
    assign jtag.user_reg  = user_q;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomized JTAG scans against a scan-level queue model of the TAP.
// A monitor compares every driven TDO bit with the scoreboard queue.
module tb_jtag_tap_responder;
    localparam int HALF = 6;
    localparam logic [31:0] IDC = 32'h1BB1_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtag_tap_responder_if jif();

    jtag_tap_responder #(
        .IDCODE(IDC),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .jtag(jif.slave)
    );

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic [3:0] m_ir;
    logic [7:0] m_user;
    logic [3:0] m_state;
    logic [31:0] m_dr;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    initial begin : monitor
        logic e;
        forever begin
            @(posedge jif.tck);
            if (jif.tdo_oe === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tdo_extra: got tdo_oe=1 tdo=%b, required no output",
                             jif.tdo);
                end else begin
                    e = exp_q.pop_front();
                    if (jif.tdo !== e) begin
                        errors++;
                        $display("FAIL tdo_bit: got %b required %b", jif.tdo, e);
                    end
                end
            end
        end
    end

    task automatic tck_cycle(input logic m, input logic d);
        jif.tms = m;
        jif.tdi = d;
        jif.tck = 1'b0;
        repeat (HALF) @(negedge clk);
        jif.tck = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Register modelled as a bit queue: capture, then pop out / push in.
    task automatic shift_bits(input bit is_ir, input int n,
                              input logic [63:0] din, input bit last_exit);
        logic rq[$];
        int L;
        logic [31:0] cap;
        if (is_ir) begin L = 4; cap = 32'h5; end
        else if (m_ir == 4'h1) begin L = 32; cap = IDC; end
        else if (m_ir == 4'h2) begin L = 8; cap = {24'h0, m_user}; end
        else begin L = 1; cap = 32'h0; end
        for (int i = 0; i < L; i++) rq.push_back(cap[i]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(rq.pop_front());
            rq.push_back(din[i]);
            tck_cycle(last_exit && (i == n - 1), din[i]);
        end
        m_dr = '0;
        for (int i = 0; i < L; i++) m_dr[i] = rq[i];
    endtask

    task automatic check_regs(input string nm);
        chk({nm, "_state"}, {28'h0, jif.tap_state}, {28'h0, m_state});
        chk({nm, "_ir"}, {28'h0, jif.ir_value}, {28'h0, m_ir});
        chk({nm, "_user"}, {24'h0, jif.user_reg}, {24'h0, m_user});
        chk({nm, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic reset_tap();
        repeat (5) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        m_ir = 4'h1;
        m_state = 4'hC;
    endtask

    task automatic ir_scan(input int n, input logic [63:0] din);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(1'b1, n, din, 1'b1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        m_ir = m_dr[3:0];
        m_state = 4'hC;
    endtask

    task automatic dr_scan(input int n, input logic [63:0] din);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(1'b0, n, din, 1'b1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        if (m_ir == 4'h2) m_user = m_dr[7:0];
        m_state = 4'hC;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_state"}, {28'h0, jif.tap_state}, 32'hF);
        chk({nm, "_ir"}, {28'h0, jif.ir_value}, 32'h1);
        chk({nm, "_user"}, {24'h0, jif.user_reg}, 32'h0);
        chk({nm, "_tdo"}, {31'h0, jif.tdo}, 32'h0);
        chk({nm, "_oe"}, {31'h0, jif.tdo_oe}, 32'h0);
    endtask

    initial begin
        int n;
        logic [63:0] d;
        logic [3:0] code;
        jif.tck = 1'b0;
        jif.tms = 1'b1;
        jif.tdi = 1'b0;
        jif.trst_n = 1'b1;
        m_ir = 4'h1;
        m_user = 8'h00;
        m_state = 4'hF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        reset_tap();
        check_regs("rti");
        dr_scan(32, {$urandom, $urandom});
        check_regs("idcode");

        ir_scan(4, 64'hF);
        check_regs("ir_bypass");
        dr_scan(8, 64'hA5);
        check_regs("bypass");

        ir_scan(4, 64'h2);
        dr_scan(8, 64'h3C);
        check_regs("user_3c");
        dr_scan(8, 64'hFF);
        check_regs("user_ff");

        // Abort from Pause-DR with IDCODE selected.
        ir_scan(4, 64'h1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(1'b0, 10, {$urandom, $urandom}, 1'b1);
        tck_cycle(1'b0, 1'b0);
        repeat (5) tck_cycle(1'b1, 1'b0);
        m_state = 4'hF;
        m_ir = 4'h1;
        check_regs("pause_tlr");
        chk("pause_oe", {31'h0, jif.tdo_oe}, 32'h0);
        tck_cycle(1'b0, 1'b0);
        m_state = 4'hC;

        // trst_n pulse while sitting in Shift-IR.
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(1'b1, 2, 64'h3, 1'b0);
        @(negedge clk);
        jif.trst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("trst_state", {28'h0, jif.tap_state}, 32'hF);
        chk("trst_ir", {28'h0, jif.ir_value}, 32'h1);
        @(negedge clk);
        jif.trst_n = 1'b1;
        repeat (4) @(negedge clk);
        m_state = 4'hF;
        m_ir = 4'h1;
        check_regs("trst");
        tck_cycle(1'b0, 1'b0);
        m_state = 4'hC;

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: code = 4'h1;
                    1: code = 4'h2;
                    2: code = 4'hF;
                    default: code = 4'($urandom);
                endcase
                n = 4 + $urandom_range(0, 2);
                d = {$urandom, $urandom};
                d[n-4 +: 4] = code;
                ir_scan(n, d);
                check_regs("rnd_ir");
            end else begin
                dr_scan($urandom_range(1, 40), {$urandom, $urandom});
                check_regs("rnd_dr");
            end
        end

        // rst_n in the middle of a USER shift.
        ir_scan(4, 64'h2);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        shift_bits(1'b0, 4, 64'h5A, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        jif.tck = 1'b0;
        jif.tms = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        m_user = 8'h00;
        m_ir = 4'h1;
        m_state = 4'hF;
        repeat (4) @(negedge clk);
        chk("midrst_drain", exp_q.size(), 0);
        reset_tap();
        dr_scan(32, {$urandom, $urandom});
        check_regs("post_rst_id");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- Target-side JTAG TAP implemented in the buffer-logic CPLD, clocked by the board oscillator.
- Responds to TCK/TMS/TDI driven by the FT2232 through the buffer path and returns TDO, so the self-test can exercise a full JTAG scan without an external target.
- Implements the IEEE 1149.1 16-state TAP controller, a 4-bit IR, and three data registers: IDCODE, BYPASS and an 8-bit USER scratch register.

Parameters:
- IDCODE, 32'h1BB1_0001, value captured in Capture-DR when IR=IDCODE; bit0 must be 1.
- SYNC_STAGES, 2, flip-flop stages on tck/tms/tdi/trst_n before use (minimum 2).

Ports:
- clk  input  1  system clock; only clock in the block.
- rst_n  input  1  asynchronous active-low reset.
- tck  input  1  raw JTAG clock from host, asynchronous to clk.
- tms  input  1  raw JTAG mode select.
- tdi  input  1  raw JTAG data in.
- trst_n  input  1  raw JTAG test reset, active low.
- tdo  output  1  JTAG data out to host.
- tdo_oe  output  1  1 = tdo valid/driven; 0 = buffer tri-states TDO.
- tap_state  output  4  current TAP state code (debug/selftest readback).
- ir_value  output  4  current instruction register.
- user_reg  output  8  USER register contents (after Update-DR).

Behaviour:
- Reset (rst_n=0, asynchronous): tap_state=TLR (4'hF), ir_value=4'b0001 (IDCODE), user_reg=8'h00, tdo=0, tdo_oe=0, shift registers=0, synchronizer and edge flops=0.
- Synchronisation: tck, tms, tdi and trst_n each pass through SYNC_STAGES flops. tck_prev holds the previous synchronized tck.
  - rise = sync_tck & ~tck_prev; fall = ~sync_tck & tck_prev.
  - tms and tdi are taken from the same synchronizer depth as tck.
  - Latency: raw tck edge to state/register update = SYNC_STAGES+1 clk.
  - Host requirement: tck high and low each >= SYNC_STAGES+2 clk periods, and tms/tdi stable from setup through that window.
- State codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- Transitions occur only on rise, using sync tms, per the 1149.1 graph:
  - TLR: 0->RTI, 1 stays.
  - RTI: 0 stays, 1->SelDR.
  - SelDR: 0->CapDR, 1->SelIR.
  - SelIR: 0->CapIR, 1->TLR.
  - Cap: 0->Sh, 1->Ex1.
  - Sh: 0 stays, 1->Ex1.
  - Ex1: 0->Pau, 1->Upd.
  - Pau: 0 stays, 1->Ex2.
  - Ex2: 0->Sh, 1->Upd.
  - Upd: 0->RTI, 1->SelDR.
- Register actions, all on the rise edge in which the state is current:
  - CapIR: ir_shift <= 4'b0101.
  - ShIR: ir_shift <= {tdi, ir_shift[3:1]}.
  - UpdIR: ir_value <= ir_shift.
  - CapDR loads dr_shift according to ir_value:
    - IDCODE (0001): 32-bit IDCODE.
    - USER (0010): {24'h0, user_reg}; only 8 bits are active.
    - BYPASS (1111) and every other code: bypass bit = 0.
  - ShDR: shift LSB-first with tdi entering at the MSB of the selected length (32, 8 or 1).
  - UpdDR with IR=USER: user_reg <= dr_shift[7:0]. Other instructions: no effect.
  - Entering TLR, or sitting in TLR: ir_value <= 0001. user_reg is not cleared.
- TDO is driven on fall only:
  - State ShIR: tdo <= ir_shift[0], tdo_oe <= 1.
  - State ShDR: tdo <= LSB of the selected DR, tdo_oe <= 1.
  - Any other state: tdo_oe <= 0, tdo <= 0.
- trst_n: sync trst_n=0 forces tap_state=TLR and ir_value=0001 on the next clk, overriding any rise. Edge tracking continues.
- Five consecutive rises with tms=1 reach TLR from any state.
- rst_n asserted mid-shift aborts immediately to the reset values. A partially shifted user value is discarded.
- Simultaneous rise and trst_n low: trst_n wins.

Test Plan:
- rst_n pulse, tms=1 x5 then 0 (RTI), 1,0,0 (CapDR->ShDR), shift 32 bits -> tdo returns 32'h1BB1_0001 LSB first, tdo_oe=1 only during the ShDR TCK periods.
- IR scan of 1111, then a DR scan of 8'hA5 -> tdo returns 0 followed by tdi delayed by exactly one TCK (1-bit bypass). IR capture returns 0101 on tdo.
- IR=0010, DR scan in 8'h3C -> user_reg=8'h3C after UpdDR. A second scan in 8'hFF -> tdo returns 8'h3C; user_reg then =8'hFF.
- From PauDR mid-shift, tms=1 x5 -> tap_state=F, ir_value=0001, tdo_oe=0, user_reg unchanged.
- trst_n low for 4 clk while in ShIR -> tap_state=F within SYNC_STAGES+1 clk, ir_value=0001.
- rst_n asserted mid-ShDR of USER 8'h5A -> all outputs at reset values, user_reg=00. A following IDCODE scan still succeeds.
